set_multi_scan: RTL and testbench

//   Parametrised successor of the 3-circle SET counter. Scans a GRID x GRID lattice (coords 1..GRID),

---
 rtl/set_multi_scan_if.sv | 25 ++
 rtl/set_multi_scan.sv | 132 +++++++++++++
 tb/tb_set_multi_scan.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/set_multi_scan_if.sv
// Job request / result bundle for the multi-circle lattice scanner.
// The master launches jobs and observes busy/valid/candidate.
interface set_multi_scan_if #(
    parameter int CW    = 4,
    parameter int NC    = 3,
    parameter int CNT_W = 7
);
    logic                 en;
    logic [NC*2*CW-1:0]   central;
    logic [NC*CW-1:0]     radius;
    logic [2**NC-1:0]     truth;
    logic                 busy;
    logic                 valid;
    logic [CNT_W-1:0]     candidate;

    modport master (
        output en, central, radius, truth,
        input  busy, valid, candidate
    );

    modport slave (
        input  en, central, radius, truth,
        output busy, valid, candidate
    );
endinterface

// File: rtl/set_multi_scan.sv
// Scans a GRID x GRID lattice, tests each point against NC circles and counts
// points whose membership vector selects a 1 in a latched truth table.
module set_multi_scan #(
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int NC    = 3,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    set_multi_scan_if.slave   bus
);

    // state | meaning
    // IDLE  | waiting for en
    // SCAN  | presenting one lattice point per clock
    // DRAIN | waiting for the point pipeline to empty
    // DONE  | valid pulse; en here starts the next job
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [CW-1:0] G = CW'(GRID);

    state_t               state, state_nxt;
    logic                 start;
    logic                 busy_c, valid_c;
    logic                 last_pt;
    logic [NC*2*CW-1:0]   cen_q;
    logic [NC*CW-1:0]     rad_q;
    logic [2**NC-1:0]     tru_q;
    logic [CW-1:0]        x, y;
    logic [NC-1:0]        m_comb, m_q;
    logic                 v1;
    logic [CNT_W-1:0]     cand;

    function automatic logic [2*CW:0] sq(input logic [CW-1:0] a);
        logic [2*CW:0] w;
        w = {{(CW+1){1'b0}}, a};
        return w * w;
    endfunction

    function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign last_pt       = (x == G) && (y == G);
    assign bus.busy      = busy_c;
    assign bus.valid     = valid_c;
    assign bus.candidate = cand;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy_c    = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    start     = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy_c = 1'b1;
                if (last_pt) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (!v1) state_nxt = DONE;
            end
            DONE: begin
                valid_c = 1'b1;
                if (bus.en) begin
                    start     = 1'b1;
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Squares are taken at 2*CW+1 bits so the distance sum cannot wrap.
    always_comb begin
        m_comb = '0;
        for (int i = 0; i < NC; i++) begin
            m_comb[i] = (sq(absdiff(x, cen_q[(2*i+1)*CW +: CW])) +
                         sq(absdiff(y, cen_q[2*i*CW +: CW])))
                        <= sq(rad_q[i*CW +: CW]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cen_q <= '0;
            rad_q <= '0;
            tru_q <= '0;
            x     <= '0;
            y     <= '0;
            m_q   <= '0;
            v1    <= 1'b0;
            cand  <= '0;
        end else begin
            v1  <= (state == SCAN);
            m_q <= m_comb;
            if (start) begin
                cen_q <= bus.central;
                rad_q <= bus.radius;
                tru_q <= bus.truth;
                cand  <= '0;
                x     <= CW'(1);
                y     <= CW'(1);
            end else begin
                if (state == SCAN && !last_pt) begin
                    if (x == G) begin
                        x <= CW'(1);
                        y <= y + CW'(1);
                    end else begin
                        x <= x + CW'(1);
                    end
                end
                if (v1) cand <= cand + {{(CNT_W-1){1'b0}}, tru_q[m_q]};
            end
        end
    end

endmodule

// File: tb/tb_set_multi_scan.sv
// Self-checking bench for set_multi_scan: per-cycle model comparison plus
// hand-computed counts for directed jobs.
module tb_set_multi_scan;
    localparam int GRID  = 8;
    localparam int CW    = 4;
    localparam int NC    = 3;
    localparam int CNT_W = 7;
    localparam int LAT   = GRID*GRID + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    set_multi_scan_if #(.CW(CW), .NC(NC), .CNT_W(CNT_W)) bus ();

    set_multi_scan #(.GRID(GRID), .CW(CW), .NC(NC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Counts lattice points directly from the circle equations.
    function automatic int model_count(input logic [23:0] c, input logic [11:0] r, input logic [7:0] t);
        int n, m, cx, cy, rr, dx, dy;
        n = 0;
        for (int px = 1; px <= GRID; px++)
            for (int py = 1; py <= GRID; py++) begin
                m = 0;
                for (int i = 0; i < NC; i++) begin
                    cx = int'(c[(2*i+1)*CW +: CW]);
                    cy = int'(c[2*i*CW +: CW]);
                    rr = int'(r[i*CW +: CW]);
                    dx = px - cx;
                    dy = py - cy;
                    if (dx*dx + dy*dy <= rr*rr) m = m | (1 << i);
                end
                if (t[m]) n++;
            end
        return n;
    endfunction

    function automatic logic [23:0] pack(input int ax, ay, bx, by, cx, cy);
        return {4'(cx), 4'(cy), 4'(bx), 4'(by), 4'(ax), 4'(ay)};
    endfunction

    // Timeline model: phase 0 idle, 1..LAT busy, LAT+1 valid cycle.
    int phase    = 0;
    int exp_cand = 0;
    int job_res  = 0;

    always @(posedge clk) begin
        if (!rst) begin
            phase    = 0;
            exp_cand = 0;
        end else if ((phase == 0 || phase == LAT+1) && bus.en) begin
            phase    = 1;
            exp_cand = 0;
            job_res  = model_count(bus.central, bus.radius, bus.truth);
        end else if (phase == LAT+1) begin
            phase = 0;
        end else if (phase > 0) begin
            phase++;
            if (phase == LAT+1) exp_cand = job_res;
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(bus.busy), int'(phase >= 1 && phase <= LAT));
        chk("valid", int'(bus.valid), int'(phase == LAT+1));
        if (phase == 0 || phase == LAT+1)
            chk("candidate", int'(bus.candidate), exp_cand);
    end

    // Called at a negedge; en is sampled at the following posedge.
    task automatic start_now(input logic [23:0] c, input logic [11:0] r, input logic [7:0] t);
        bus.central = c;
        bus.radius  = r;
        bus.truth   = t;
        bus.en      = 1'b1;
        @(negedge clk);
        bus.en      = 1'b0;
    endtask

    task automatic wait_valid(output int busy_cycles);
        bit ok;
        ok = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.valid) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
        chk("valid_timeout", int'(ok), 1);
    endtask

    task automatic run_job(input string name, input logic [23:0] c, input logic [11:0] r,
                           input logic [7:0] t, input int exp);
        int bc;
        @(negedge clk);
        start_now(c, r, t);
        wait_valid(bc);
        chk(name, int'(bus.candidate), exp);
        chk({name, "_busy_len"}, bc, LAT);
    endtask

    localparam logic [11:0] R_A2   = {4'd0, 4'd0, 4'd2};
    localparam logic [11:0] R_AB2  = {4'd0, 4'd2, 4'd2};
    localparam logic [11:0] R_A3   = {4'd0, 4'd0, 4'd3};

    initial begin
        int bc;
        bit seen;
        logic [23:0] c_a44, c_ab, c_a11;
        c_a44 = pack(4, 4, 0, 0, 0, 0);
        c_ab  = pack(3, 3, 5, 5, 0, 0);
        c_a11 = pack(1, 1, 0, 0, 0, 0);

        bus.en = 1'b0; bus.central = '0; bus.radius = '0; bus.truth = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_candidate", int'(bus.candidate), 0);
        rst = 1'b1;

        run_job("a_only", c_a44, R_A2, 8'hAA, 13);
        run_job("a_and_b", c_ab, R_AB2, 8'h88, 3);
        run_job("a_xor_b", c_ab, R_AB2, 8'h66, 20);
        run_job("edge_clip", c_a11, R_A3, 8'hAA, 11);
        run_job("truth_none", c_a11, R_A3, 8'h00, 0);
        run_job("truth_all", c_a11, R_A3, 8'hFF, 64);

        // en and input changes mid-job are ignored
        @(negedge clk);
        start_now(c_a44, R_A2, 8'hAA);
        repeat (9) @(negedge clk);
        bus.central = c_ab;
        bus.truth   = 8'hFF;
        bus.en      = 1'b1;
        @(negedge clk);
        bus.en      = 1'b0;
        wait_valid(bc);
        chk("ignore_en", int'(bus.candidate), 13);

        // back-to-back start from the valid cycle
        start_now(c_ab, R_AB2, 8'h88);
        chk("b2b_busy", int'(bus.busy), 1);
        wait_valid(bc);
        chk("b2b_result", int'(bus.candidate), 3);

        // reset mid-scan abandons the job
        @(negedge clk);
        start_now(c_a44, R_A2, 8'hAA);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_valid", int'(bus.valid), 0);
        chk("midrst_candidate", int'(bus.candidate), 0);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.valid) seen = 1'b1;
        end
        chk("midrst_no_valid", int'(seen), 0);
        run_job("after_rst", c_a44, R_A2, 8'hAA, 13);

        // exactly two of three circles
        @(negedge clk);
        start_now(pack(3, 3, 5, 5, 4, 4), {4'd1, 4'd2, 4'd2}, 8'h68);
        wait_valid(bc);
        chk("two_of_three", int'(bus.candidate),
            model_count(pack(3, 3, 5, 5, 4, 4), {4'd1, 4'd2, 4'd2}, 8'h68));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
